pc_fetch_stage: RTL and testbench
=================================

# pc_fetch_stage

Program-counter register and instruction-fetch sequencer. Holds `CurrentPC` and fetches the instruction word at that address from instruction memory over a request/grant/response interface. Presents the instruction to decode with a valid/ready handshake, then loads the resolved `NextPC` from the next-PC logic. Runs one instruction in flight, non-pipelined.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded by reset; must be 4-byte aligned.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `NextPC`  in  64  resolved next PC for the instruction currently handed off.
- `NextPCValid`  in  1  `NextPC` is valid this cycle.
- `ImemReq`  out  1  fetch request.
- `ImemAddr`  out  64  fetch address; always equals `CurrentPC`.
- `ImemGnt`  in  1  memory accepts the request this cycle.
- `ImemRspValid`  in  1  response word valid this cycle.
- `ImemRspData`  in  32  instruction word.
- `InstrValid`  out  1  `Instruction` is valid for decode.
- `Instruction`  out  32  captured instruction word.
- `InstrReady`  in  1  decode accepts the instruction.
- `CurrentPC`  out  64  PC register; drives the next-PC logic and `ImemAddr`.
- `FetchCount`  out  32  number of completed decode handoffs; wraps modulo 2^32.
- `PCFault`  out  1  sticky misaligned-`NextPC` flag.

## Operation
- The state machine has five states: FETCH, WAIT, HOLD, RESOLVE, FAULT. The reset state is FETCH.
- **FETCH:** `ImemReq`=1.
  - `ImemGnt`=1 → go to WAIT.
  - Otherwise stay in FETCH, holding `ImemAddr` stable.
- **WAIT:** `ImemReq`=0.
  - `ImemRspValid`=1 → `Instruction` <= `ImemRspData`, go to HOLD.
  - Otherwise stay in WAIT.
- **HOLD:** `InstrValid`=1. `Instruction` is stable until the handoff. A handoff is `InstrValid` && `InstrReady`.
  - Handoff with `NextPCValid`=1 in the same cycle → resolve immediately (see PC load rule), skipping RESOLVE.
  - Handoff without `NextPCValid` → go to RESOLVE.
  - No handoff → stay in HOLD.
- **RESOLVE:** `InstrValid`=0. Wait for `NextPCValid`=1, then apply the PC load rule.
- **PC load rule:**
  - `NextPC[1:0]`==0 → `CurrentPC` <= `NextPC`, go to FETCH.
  - Otherwise `CurrentPC` is unchanged, `PCFault` <= 1, go to FAULT.
- **FAULT:** all handshake outputs are 0. The block stays in FAULT until `Reset`.
- **Ignored inputs:**
  - `NextPCValid` outside HOLD and RESOLVE.
  - `ImemRspValid` outside WAIT.
  - `ImemGnt` outside FETCH.
- `FetchCount` increments by 1 on every handoff cycle; 32'hFFFFFFFF wraps to 0.
- **Reset values:** `CurrentPC`=`RESET_PC`, `Instruction`=0, `FetchCount`=0, `PCFault`=0, state=FETCH.
- **During `Reset`:** `ImemReq`=0 and `InstrValid`=0, regardless of other inputs.
- **Reset mid-operation:** `Reset` in any state, including WAIT with a response outstanding or FAULT, returns the block to reset values on the next edge. A late response arriving after reset lands in FETCH and is ignored.

## Timing
- `ImemReq` and `InstrValid` are decoded from the registered state only, never from same-cycle inputs. `ImemAddr` equals `CurrentPC` (registered).
- Memory responses must arrive no earlier than the cycle after the grant. A response in the grant cycle is ignored.
- **Best case**, grant in the first FETCH cycle and response in the next cycle:
  - FETCH at cycle n, WAIT at n+1, HOLD (`InstrValid`=1) at n+2.
  - With `InstrReady` and `NextPCValid` both high at n+2: `CurrentPC` updates and FETCH is entered at n+3.
  - Throughput is 3 cycles per instruction.
- Each extra cycle of grant delay, response delay, `InstrReady` delay or `NextPCValid` delay adds exactly one cycle.
- The first `ImemReq` is in the first cycle after `Reset` deasserts.

## Test plan
- **Reset values:** hold `Reset` 2 cycles with `RESET_PC`=64'h10 → `CurrentPC`=64'h10, `ImemReq`=0, `InstrValid`=0, `FetchCount`=0, `PCFault`=0. The first cycle after release gives `ImemReq`=1 with `ImemAddr`=64'h10.
- **Best-case sequence:**
  - Grant immediately, respond next cycle with 32'h8B020020, `InstrReady`=1, `NextPC`=64'h14 with `NextPCValid`=1.
  - `InstrValid` rises 2 cycles after the grant; `FetchCount`=1.
  - `ImemAddr`=64'h14 on the following cycle; 3 cycles per instruction over 4 consecutive fetches (64'h10, 64'h14, 64'h18, 64'h1C).
- **Backpressure:**
  - Delay `ImemGnt` 3 cycles → `ImemAddr` is stable throughout.
  - Hold `InstrReady`=0 for 5 cycles → `Instruction` is stable and `FetchCount` is unchanged.
  - Assert `NextPCValid`=1 while in WAIT → it is ignored.
- **Branch redirect:** handoff without `NextPCValid`, then `NextPC`=64'h20 two cycles later → `CurrentPC`=64'h20 one cycle after `NextPCValid`, then FETCH.
- **Misaligned target:** `NextPC`=64'h22 → `PCFault`=1, `CurrentPC` is unchanged, `ImemReq` stays 0 for 10 cycles. `Reset` clears the fault and `ImemAddr` returns to `RESET_PC`.
- **Reset mid-WAIT:** assert `Reset` after the grant, then pulse `ImemRspValid` on the first cycle after release → `InstrValid` stays 0 and the block is in FETCH at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program-counter register and single-outstanding instruction fetch sequencer.
// Fetches the word at CurrentPC, hands it to decode, then loads the resolved next PC.
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [63:0] NextPC,
    input  logic        NextPCValid,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    input  logic        InstrReady,
    output logic [63:0] CurrentPC,
    output logic [31:0] FetchCount,
    output logic        PCFault,
    output logic [2:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where the sender's
    // valid/request and the receiver's ready/grant are both high. Outputs
    // ImemReq and InstrValid come from registered state only and, once raised,
    // stay high with stable payload until the transfer completes.

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_WAIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_RESOLVE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;
    logic   handoff;
    logic   resolve;
    logic   pc_ok;

    always_comb begin
        next_state = state;
        handoff    = 1'b0;
        resolve    = 1'b0;
        pc_ok      = (NextPC[1:0] == 2'b00);
        case (state)
            S_FETCH: begin
                if (ImemGnt) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (ImemRspValid) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (InstrReady) begin
                    handoff = 1'b1;
                    if (NextPCValid) begin
                        resolve    = 1'b1;
                        next_state = pc_ok ? S_FETCH : S_FAULT;
                    end else begin
                        next_state = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                if (NextPCValid) begin
                    resolve    = 1'b1;
                    next_state = pc_ok ? S_FETCH : S_FAULT;
                end
            end
            S_FAULT: begin
                next_state = S_FAULT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_FETCH;
            CurrentPC   <= RESET_PC;
            Instruction <= 32'h0;
            FetchCount  <= 32'h0;
            PCFault     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && ImemRspValid) Instruction <= ImemRspData;
            if (handoff) FetchCount <= FetchCount + 32'd1;
            // A misaligned target keeps the old PC so the faulting instruction can be located.
            if (resolve) begin
                if (pc_ok) CurrentPC <= NextPC;
                else       PCFault   <= 1'b1;
            end
        end
    end

    assign ImemReq    = (state == S_FETCH) && !Reset;
    assign InstrValid = (state == S_HOLD) && !Reset;
    assign ImemAddr   = CurrentPC;
    assign fsm_state  = state;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: drives fetch transactions with chosen
// delays; a monitor compares every decode handoff against an expected queue.
module tb_pc_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] NextPC;
    logic        NextPCValid;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic        InstrReady;
    logic [63:0] CurrentPC;
    logic [31:0] FetchCount;
    logic        PCFault;
    logic [2:0]  fsm_state;

    pc_fetch_stage #(.RESET_PC(64'h10)) dut (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .NextPCValid(NextPCValid),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .InstrValid(InstrValid), .Instruction(Instruction), .InstrReady(InstrReady),
        .CurrentPC(CurrentPC), .FetchCount(FetchCount), .PCFault(PCFault),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hand_cnt = 0;
    logic [95:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (InstrValid && InstrReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handoff", 64'd1, 64'd0);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("handoff_pc", CurrentPC, e[95:32]);
                check("handoff_instr", {32'h0, Instruction}, {32'h0, e[31:0]});
            end
            check("fetch_count", {32'h0, FetchCount}, hand_cnt);
            hand_cnt++;
        end
    end

    // ---------------- driver ----------------
    // Entered right after an edge with the DUT in FETCH. Junk NextPCValid and
    // early responses are driven where they must be ignored.
    task automatic fetch_one(input logic [63:0] pc, input logic [31:0] word,
                             input int gnt_dly, input int rsp_dly, input int rdy_dly,
                             input int npc_dly, input logic [63:0] npc);
        int start;
        logic [31:0] fc_hold;
        start = cyc;
        exp_q.push_back({pc, word});
        for (int i = 0; i < gnt_dly; i++) begin
            ImemGnt = 1'b0; NextPCValid = 1'b1; NextPC = 64'h22;
            #1;
            check("req_while_wait_gnt", {63'h0, ImemReq}, 64'd1);
            check("addr_stable", ImemAddr, pc);
            tick();
        end
        ImemGnt = 1'b1; ImemRspValid = 1'b1; ImemRspData = 32'hDEADBEEF;
        NextPCValid = 1'b1; NextPC = 64'h22;
        #1;
        check("req_grant_cycle", {63'h0, ImemReq}, 64'd1);
        check("addr_grant_cycle", ImemAddr, pc);
        tick();
        ImemGnt = 1'b0; ImemRspValid = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            #1;
            check("req_low_in_wait", {63'h0, ImemReq}, 64'd0);
            check("ivalid_low_in_wait", {63'h0, InstrValid}, 64'd0);
            tick();
        end
        ImemRspValid = 1'b1; ImemRspData = word;
        tick();
        ImemRspValid = 1'b0; ImemRspData = $urandom; NextPCValid = 1'b0;
        fc_hold = FetchCount;
        for (int i = 0; i < rdy_dly; i++) begin
            InstrReady = 1'b0;
            #1;
            check("ivalid_hold", {63'h0, InstrValid}, 64'd1);
            check("instr_stable", {32'h0, Instruction}, {32'h0, word});
            check("count_stable", {32'h0, FetchCount}, {32'h0, fc_hold});
            tick();
        end
        InstrReady = 1'b1; NextPC = npc; NextPCValid = (npc_dly == 0);
        #1;
        check("ivalid_handoff", {63'h0, InstrValid}, 64'd1);
        tick();
        InstrReady = 1'b0;
        if (npc_dly > 0) begin
            NextPCValid = 1'b0;
            for (int i = 0; i < npc_dly - 1; i++) begin
                #1;
                check("ivalid_low_resolve", {63'h0, InstrValid}, 64'd0);
                check("pc_hold_resolve", CurrentPC, pc);
                tick();
            end
            NextPCValid = 1'b1; NextPC = npc;
            tick();
        end
        NextPCValid = 1'b0;
        #1;
        check("latency", cyc - start, 3 + gnt_dly + rsp_dly + rdy_dly + npc_dly);
        if (npc[1:0] == 2'b00) begin
            check("pc_loaded", CurrentPC, npc);
            check("next_req", {63'h0, ImemReq}, 64'd1);
            check("next_addr", ImemAddr, npc);
        end else begin
            check("pc_kept", CurrentPC, pc);
            check("fault_set", {63'h0, PCFault}, 64'd1);
        end
    endtask

    task automatic check_reset_values();
        check("rst_pc", CurrentPC, 64'h10);
        check("rst_req", {63'h0, ImemReq}, 64'd0);
        check("rst_ivalid", {63'h0, InstrValid}, 64'd0);
        check("rst_count", {32'h0, FetchCount}, 64'd0);
        check("rst_fault", {63'h0, PCFault}, 64'd0);
        check("rst_instr", {32'h0, Instruction}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; NextPC = 64'h0; NextPCValid = 1'b0; ImemGnt = 1'b1;
        ImemRspValid = 1'b1; ImemRspData = 32'hFFFFFFFF; InstrReady = 1'b1;
        tick();
        tick();
        #1;
        check_reset_values();
        Reset = 1'b0; ImemGnt = 1'b0; ImemRspValid = 1'b0; InstrReady = 1'b0;
        #1;
        check("first_req", {63'h0, ImemReq}, 64'd1);
        check("first_addr", ImemAddr, 64'h10);

        // best case, four back-to-back fetches
        fetch_one(64'h10, 32'h8B020020, 0, 0, 0, 0, 64'h14);
        check("count_after_first", {32'h0, FetchCount}, 64'd1);
        fetch_one(64'h14, 32'h91000421, 0, 0, 0, 0, 64'h18);
        fetch_one(64'h18, 32'hF9400042, 0, 0, 0, 0, 64'h1C);
        fetch_one(64'h1C, 32'hD503201F, 0, 0, 0, 0, 64'h30);
        // branch redirect resolved two cycles after the handoff
        fetch_one(64'h30, 32'h14000004, 0, 0, 0, 2, 64'h20);
        // backpressure on every handshake
        fetch_one(64'h20, 32'hAA0103E0, 3, 2, 5, 0, 64'h24);
        // misaligned target
        fetch_one(64'h24, 32'hD65F03C0, 1, 0, 1, 1, 64'h22);
        for (int i = 0; i < 10; i++) begin
            ImemGnt = 1'b1; NextPCValid = 1'b1; NextPC = 64'h40; InstrReady = 1'b1;
            #1;
            check("fault_req_low", {63'h0, ImemReq}, 64'd0);
            check("fault_ivalid_low", {63'h0, InstrValid}, 64'd0);
            tick();
        end
        check("fault_sticky", {63'h0, PCFault}, 64'd1);
        check("fault_pc_kept", CurrentPC, 64'h24);
        check("count_before_reset", {32'h0, FetchCount}, 64'd7);
        ImemGnt = 1'b0; NextPCValid = 1'b0; InstrReady = 1'b0;
        Reset = 1'b1; hand_cnt = 0;
        tick();
        Reset = 1'b0;
        #1;
        check("fault_cleared", {63'h0, PCFault}, 64'd0);
        check("addr_back_to_reset", ImemAddr, 64'h10);
        check("req_after_fault_reset", {63'h0, ImemReq}, 64'd1);
        check("count_cleared", {32'h0, FetchCount}, 64'd0);

        // reset while a response is outstanding
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        check("in_wait", {61'h0, fsm_state}, 64'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ImemRspValid = 1'b1; ImemRspData = 32'h12345678;
        #1;
        check("midwait_fetch_state", {61'h0, fsm_state}, 64'd0);
        check("midwait_addr", ImemAddr, 64'h10);
        tick();
        ImemRspValid = 1'b0;
        #1;
        check("late_rsp_ivalid", {63'h0, InstrValid}, 64'd0);
        check("late_rsp_state", {61'h0, fsm_state}, 64'd0);
        check("late_rsp_instr", {32'h0, Instruction}, 64'd0);

        // recovery fetch
        fetch_one(64'h10, 32'h52800020, 1, 1, 2, 1, 64'h14);
        check("final_count", {32'h0, FetchCount}, 64'd1);
        check("queue_drained", exp_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
